// File: rtl/custom_stage_ctrl.sv
// Stage sequencer for the custom accelerator datapath: steps a stage count
// through 0..LAST_STAGE with stall/abort handling and a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; cnt parked at 0
// RUN   | stepping stages, cnt held while stalled
// DONE  | run complete, done held until done_ack
module custom_stage_ctrl #(
    parameter int CNT_W      = 5,
    parameter int LAST_STAGE = 25,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              abort_i,
    input  logic              done_ack_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              stage_valid_o,
    output logic              first_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LAST_STAGE);
    localparam logic [PERF_W-1:0] STALL_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        valid_d     = 1'b0;

        // Abort wins over everything; the perf counter is kept for post-mortem.
        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (start_i) begin
                        state_d     = ST_RUN;
                        stall_cnt_d = '0;
                        valid_d     = !stall_i;
                    end
                end
                ST_RUN: begin
                    if (stall_i) begin
                        if (stall_cnt_q != STALL_MAX) begin
                            stall_cnt_d = stall_cnt_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    cnt_d = '0;
                    if (done_ack_i) begin
                        if (start_i) begin
                            state_d     = ST_RUN;
                            stall_cnt_d = '0;
                            valid_d     = !stall_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Qualifiers come from next-state values so they line up with cnt_q.
    always_comb begin
        first_d = valid_d && (cnt_d == '0);
        last_d  = valid_d && (cnt_d == CNT_LAST);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign stage_valid_o = valid_q;
    assign first_o       = first_q;
    assign last_o        = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_custom_stage_ctrl.sv
// Directed bench for custom_stage_ctrl: full runs, stalls, done hold,
// back-to-back start, abort and asynchronous reset.
module tb_custom_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i, stall_i, abort_i, done_ack_i;
    logic [4:0]  cnt_o;
    logic        stage_valid_o, first_o, last_o, busy_o, done_o;
    logic [15:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;
    int n;

    custom_stage_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .abort_i       (abort_i),
        .done_ack_i    (done_ack_i),
        .cnt_o         (cnt_o),
        .stage_valid_o (stage_valid_o),
        .first_o       (first_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp_v);
        end
    endtask

    // inputs change and outputs are sampled on the falling edge
    task automatic adv();
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done_o && cycles < budget) begin
            adv();
            cycles++;
        end
    endtask

    initial begin
        rst_n = 1'b1; start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0; done_ack_i = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset", {cnt_o, stage_valid_o, first_o, last_o, busy_o, done_o, stall_cnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();

        // full run without stalls: stages 0..25 on cycles 1..26, done on 27
        start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int i = 0; i < 26; i++) begin
            chk($sformatf("s1_stage%0d", i),
                {cnt_o, stage_valid_o, first_o, last_o, done_o, busy_o},
                {5'(i), 1'b1, (i == 0), (i == 25), 1'b0, 1'b1});
            adv();
        end
        chk("s1_done", {cnt_o, stage_valid_o, busy_o, done_o}, {5'd0, 1'b0, 1'b0, 1'b1});
        chk("s1_stall_cnt", stall_cnt_o, 32'd0);

        // done held without ack; start alone must not restart
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            adv();
            chk("hold_done", {cnt_o, stage_valid_o, busy_o, done_o}, {5'd0, 1'b0, 1'b0, 1'b1});
        end
        start_i = 1'b0;
        done_ack_i = 1'b1;
        adv();
        done_ack_i = 1'b0;
        chk("ack_to_idle", {busy_o, done_o}, 32'd0);
        adv();
        chk("idle_stays", {cnt_o, busy_o, done_o}, 32'd0);

        // stall for 3 cycles at cnt=10, start held high to show it is ignored
        start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) adv();
        chk("s2_at10", {cnt_o, stage_valid_o}, {5'd10, 1'b1});
        stall_i = 1'b1;
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv();
            chk("s2_hold10", {cnt_o, stage_valid_o, busy_o}, {5'd10, 1'b0, 1'b1});
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        adv();
        chk("s2_resume11", {cnt_o, stage_valid_o}, {5'd11, 1'b1});
        wait_done(40, n);
        chk("s2_latency", 15 + n, 32'd30);
        chk("s2_stall_cnt", stall_cnt_o, 32'd3);

        // ack and start together: straight back into RUN
        done_ack_i = 1'b1;
        start_i = 1'b1;
        adv();
        done_ack_i = 1'b0;
        start_i = 1'b0;
        chk("b2b_entry", {busy_o, cnt_o, stage_valid_o, first_o, done_o}, {1'b1, 5'd0, 1'b1, 1'b1, 1'b0});
        chk("b2b_stall_clr", stall_cnt_o, 32'd0);
        wait_done(40, n);
        chk("b2b_latency", 1 + n, 32'd27);
        done_ack_i = 1'b1;
        adv();
        done_ack_i = 1'b0;
        chk("b2b_ack", {busy_o, done_o}, 32'd0);

        // abort at cnt=17 with stall also high; stall_cnt retained at 2
        start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) adv();
        stall_i = 1'b1;
        adv();
        adv();
        chk("s4_stall5", {cnt_o, stage_valid_o}, {5'd5, 1'b0});
        stall_i = 1'b0;
        for (int i = 0; i < 12; i++) adv();
        chk("s4_at17", {cnt_o, stall_cnt_o}, {5'd17, 16'd2});
        abort_i = 1'b1;
        stall_i = 1'b1;
        adv();
        abort_i = 1'b0;
        stall_i = 1'b0;
        chk("abort_clear", {cnt_o, busy_o, done_o, stage_valid_o}, 32'd0);
        chk("abort_keep_stall", stall_cnt_o, 32'd2);
        adv();
        chk("abort_idle", {cnt_o, busy_o, done_o}, 32'd0);
        start_i = 1'b1;
        adv();
        start_i = 1'b0;
        wait_done(40, n);
        chk("post_abort_latency", 1 + n, 32'd27);
        done_ack_i = 1'b1;
        adv();
        done_ack_i = 1'b0;

        // asynchronous reset at cnt=5 after one stall
        start_i = 1'b1;
        adv();
        start_i = 1'b0;
        adv();
        stall_i = 1'b1;
        adv();
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) adv();
        chk("s5_at5", {cnt_o, stall_cnt_o}, {5'd5, 16'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {cnt_o, stage_valid_o, first_o, last_o, busy_o, done_o, stall_cnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        adv();
        chk("rst_needs_start", {cnt_o, busy_o, done_o}, 32'd0);

        // start with stall at entry: first RUN cycle not valid
        start_i = 1'b1;
        stall_i = 1'b1;
        adv();
        start_i = 1'b0;
        stall_i = 1'b0;
        chk("entry_stall", {busy_o, cnt_o, stage_valid_o, first_o}, {1'b1, 5'd0, 1'b0, 1'b0});
        adv();
        chk("entry_resume", {cnt_o, stage_valid_o}, {5'd1, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
